teletext_attr_decoder: RTL

Per-character attribute engine for Mode 7 teletext. It takes each 7-bit character code on the SA_F1 character strobe and decodes serial control codes (colour, graphics, flash, double height, background). It produces the code for the character ROM plus foreground/background, mosaic and height attributes, one character slot later. It sits between the display-memory data bus and the character-generator/RGB stage.

---
 rtl/ttx_pkg.sv | 42 ++++
 rtl/teletext_attr_decoder_if.sv | 30 +++
 rtl/ttx_flash_timer.sv | 35 +++
 rtl/teletext_attr_decoder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ttx_pkg.sv
// Shared constants and attribute record for the teletext attribute decoder.
// Control-code values, row-default colours and the per-slot attribute struct.
package ttx_pkg;

  localparam logic [6:0] TTX_ALPHA_BASE = 7'h00;
  localparam logic [6:0] TTX_GFX_BASE   = 7'h10;
  localparam logic [6:0] TTX_FLASH      = 7'h08;
  localparam logic [6:0] TTX_STEADY     = 7'h09;
  localparam logic [6:0] TTX_NORMAL_H   = 7'h0C;
  localparam logic [6:0] TTX_DOUBLE_H   = 7'h0D;
  localparam logic [6:0] TTX_CONTIG     = 7'h19;
  localparam logic [6:0] TTX_SEPAR      = 7'h1A;
  localparam logic [6:0] TTX_BLACK_BG   = 7'h1C;
  localparam logic [6:0] TTX_NEW_BG     = 7'h1D;
  localparam logic [6:0] TTX_HOLD       = 7'h1E;
  localparam logic [6:0] TTX_RELEASE    = 7'h1F;
  localparam logic [6:0] TTX_SPACE      = 7'h20;

  localparam logic [2:0] TTX_DEF_FG = 3'b111;
  localparam logic [2:0] TTX_DEF_BG = 3'b000;

  typedef struct packed {
    logic [2:0] fg;
    logic [2:0] bg;
    logic       gfx_mode;
    logic       sep;
    logic       flash;
    logic       dh;
  } ttx_attr_t;

  function automatic ttx_attr_t ttx_row_default();
    ttx_attr_t a;
    a.fg       = TTX_DEF_FG;
    a.bg       = TTX_DEF_BG;
    a.gfx_mode = 1'b0;
    a.sep      = 1'b0;
    a.flash    = 1'b0;
    a.dh       = 1'b0;
    return a;
  endfunction

endpackage

// File: rtl/teletext_attr_decoder_if.sv
// Bus bundle between display memory / timing and the attribute decoder.
// slave: decoder side (timing + DATABUS in, char/attr out); master: driver.
interface teletext_attr_decoder_if;

  logic       SA_F1;
  logic       VSYNC;
  logic       HSYNC;
  logic       DISEN;
  logic [6:0] DATABUS;
  logic [6:0] CODE;
  logic       GFX;
  logic       SEP;
  logic [2:0] FG;
  logic [2:0] BG;
  logic       HIDE;
  logic       DH;
  logic       DH_LOWER;
  logic [3:0] LINE;

  modport master (
    output SA_F1, VSYNC, HSYNC, DISEN, DATABUS,
    input  CODE, GFX, SEP, FG, BG, HIDE, DH, DH_LOWER, LINE
  );

  modport slave (
    input  SA_F1, VSYNC, HSYNC, DISEN, DATABUS,
    output CODE, GFX, SEP, FG, BG, HIDE, DH, DH_LOWER, LINE
  );

endinterface

// File: rtl/ttx_flash_timer.sv
// Flash phase timer: counts VSYNC rising edges (sampled on i_stb).
// Ports: i_clk, i_rst_n, i_stb, i_vsync in; o_off high in hidden phase.
module ttx_flash_timer #(
  parameter int ON_FIELDS  = 48,
  parameter int OFF_FIELDS = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_stb,
  input  logic i_vsync,
  output logic o_off
);

  localparam int TOTAL = ON_FIELDS + OFF_FIELDS;
  localparam int CW    = (TOTAL > 2) ? $clog2(TOTAL) : 1;
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ONC  = CW'(ON_FIELDS);

  logic          r_vs_q;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vs_q <= 1'b0;
      r_cnt  <= '0;
    end else if (i_stb) begin
      r_vs_q <= i_vsync;
      if (i_vsync && !r_vs_q)
        r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_off = (r_cnt >= ONC);

endmodule

// File: rtl/teletext_attr_decoder.sv
// Mode 7 serial-attribute engine: one char slot in, ROM code + attrs out.
// Ports: CLK, nRESET (async low), ttx (slave bundle). Option: TTX_HOLD_GFX_EN.
module teletext_attr_decoder
  import ttx_pkg::*;
#(
  parameter int LINES_PER_ROW    = 10,
  parameter int FLASH_ON_FIELDS  = 48,
  parameter int FLASH_OFF_FIELDS = 16
) (
  input  logic                    CLK,
  input  logic                    nRESET,
  teletext_attr_decoder_if.slave  ttx
);

  localparam logic [3:0] LAST_LINE = 4'(LINES_PER_ROW - 1);

  logic [6:0] w_d;
  logic       w_slot;
  logic       w_hs_fall;
  logic       w_ctrl;
  logic       w_off;
  logic       w_gfx_char;
  logic       w_alpha_col;
  logic       w_gfx_col;
  logic       w_row_dh;
  logic       w_hold_emit;
  logic       w_held_sep;
  logic [6:0] w_held_code;
  logic [6:0] w_code;
  logic       w_gfx;
  logic       w_sep;

  ttx_attr_t  r_attr;
  ttx_attr_t  w_cur;
  ttx_attr_t  w_nxt;

  logic       r_hs_q;
  logic [3:0] r_line;
  logic       r_dh_lower;
  logic       r_row_dh;
  logic [6:0] r_code;
  logic       r_gfx;
  logic       r_sep;
  logic [2:0] r_fg;
  logic [2:0] r_bg;
  logic       r_hide;
  logic       r_dh;

  assign w_d       = ttx.DATABUS;
  assign w_slot    = ttx.SA_F1 & ttx.DISEN;
  assign w_hs_fall = ttx.SA_F1 & r_hs_q & ~ttx.HSYNC;
  assign w_ctrl    = (w_d[6:5] == 2'b00);

  assign w_alpha_col = (w_d[6:3] == TTX_ALPHA_BASE[6:3])
                     && (w_d[2:0] != 3'd0);
  assign w_gfx_col   = (w_d[6:3] == TTX_GFX_BASE[6:3])
                     && (w_d[2:0] != 3'd0);

  assign w_row_dh = r_row_dh
                  | (w_slot & (w_d == TTX_DOUBLE_H));

  ttx_flash_timer #(
    .ON_FIELDS  (FLASH_ON_FIELDS),
    .OFF_FIELDS (FLASH_OFF_FIELDS)
  ) u_flash (
    .i_clk   (CLK),
    .i_rst_n (nRESET),
    .i_stb   (ttx.SA_F1),
    .i_vsync (ttx.VSYNC),
    .o_off   (w_off)
  );

  // Set-at codes: visible on the slot that carries them.
  always_comb begin
    w_cur = r_attr;
    unique case (1'b1)
      (w_d == TTX_STEADY):   w_cur.flash = 1'b0;
      (w_d == TTX_NORMAL_H): w_cur.dh    = 1'b0;
      (w_d == TTX_CONTIG):   w_cur.sep   = 1'b0;
      (w_d == TTX_SEPAR):    w_cur.sep   = 1'b1;
      (w_d == TTX_BLACK_BG): w_cur.bg    = 3'd0;
      (w_d == TTX_NEW_BG):   w_cur.bg    = r_attr.fg;
      default: ;
    endcase
  end

  // Set-after codes: held back one slot by committing into r_attr.
  always_comb begin
    w_nxt = w_cur;
    unique case (1'b1)
      w_alpha_col: begin
        w_nxt.gfx_mode = 1'b0;
        w_nxt.fg       = w_d[2:0];
      end
      w_gfx_col: begin
        w_nxt.gfx_mode = 1'b1;
        w_nxt.fg       = w_d[2:0];
      end
      (w_d == TTX_FLASH):    w_nxt.flash = 1'b1;
      (w_d == TTX_DOUBLE_H): w_nxt.dh    = 1'b1;
      default: ;
    endcase
  end

  // Bit 5 picks mosaic cells; 0x40..0x5F has bit 5 clear (blast-through).
  assign w_gfx_char = w_cur.gfx_mode & w_d[5];

`ifdef TTX_HOLD_GFX_EN
  logic       r_hold;
  logic       r_held_vld;
  logic       r_held_sep_q;
  logic [6:0] r_held_code_q;
  logic       r_last_gfx;
  logic       r_last_dh;
  logic       w_hold_cur;
  logic       w_mode_chg;

  assign w_hold_cur  = r_hold | (w_d == TTX_HOLD);
  assign w_hold_emit = w_ctrl & w_hold_cur & r_held_vld;
  assign w_held_code = r_held_code_q;
  assign w_held_sep  = r_held_sep_q;
  // A mode/height switch drops the held cell once it is in force,
  // i.e. after the first slot that runs with the new setting.
  assign w_mode_chg  = (w_cur.gfx_mode != r_last_gfx)
                     | (w_cur.dh != r_last_dh);

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_hold        <= 1'b0;
      r_held_vld    <= 1'b0;
      r_held_sep_q  <= 1'b0;
      r_held_code_q <= TTX_SPACE;
      r_last_gfx    <= 1'b0;
      r_last_dh     <= 1'b0;
    end else if (w_hs_fall) begin
      r_hold     <= 1'b0;
      r_held_vld <= 1'b0;
      r_last_gfx <= 1'b0;
      r_last_dh  <= 1'b0;
    end else if (w_slot) begin
      r_hold     <= w_hold_cur & (w_d != TTX_RELEASE);
      r_last_gfx <= w_cur.gfx_mode;
      r_last_dh  <= w_cur.dh;
      if (w_gfx_char) begin
        r_held_code_q <= w_d;
        r_held_sep_q  <= w_cur.sep;
        r_held_vld    <= 1'b1;
      end else if (w_mode_chg) begin
        r_held_vld <= 1'b0;
      end
    end
  end
`else
  assign w_hold_emit = 1'b0;
  assign w_held_code = TTX_SPACE;
  assign w_held_sep  = 1'b0;
`endif

  always_comb begin
    w_code = w_d;
    w_gfx  = w_gfx_char;
    w_sep  = w_gfx_char & w_cur.sep;
    if (w_ctrl) begin
      w_code = w_hold_emit ? w_held_code : TTX_SPACE;
      w_gfx  = w_hold_emit;
      w_sep  = w_hold_emit & w_held_sep;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_attr     <= ttx_row_default();
      r_hs_q     <= 1'b0;
      r_line     <= 4'd0;
      r_dh_lower <= 1'b0;
      r_row_dh   <= 1'b0;
      r_code     <= TTX_SPACE;
      r_gfx      <= 1'b0;
      r_sep      <= 1'b0;
      r_fg       <= TTX_DEF_FG;
      r_bg       <= TTX_DEF_BG;
      r_hide     <= 1'b0;
      r_dh       <= 1'b0;
    end else if (ttx.SA_F1) begin
      r_hs_q   <= ttx.HSYNC;
      r_row_dh <= w_row_dh;
      if (ttx.VSYNC) begin
        r_line     <= 4'd0;
        r_dh_lower <= 1'b0;
        r_row_dh   <= 1'b0;
      end else if (w_hs_fall) begin
        if (r_line == LAST_LINE) begin
          r_line     <= 4'd0;
          r_dh_lower <= w_row_dh & ~r_dh_lower;
          r_row_dh   <= 1'b0;
        end else begin
          r_line <= r_line + 4'd1;
        end
      end
      if (w_hs_fall)
        r_attr <= ttx_row_default();
      else if (w_slot)
        r_attr <= w_nxt;
      if (w_slot) begin
        r_code <= w_code;
        r_gfx  <= w_gfx;
        r_sep  <= w_sep;
        r_fg   <= w_cur.fg;
        r_bg   <= w_cur.bg;
        r_hide <= w_cur.flash & w_off;
        r_dh   <= w_cur.dh;
      end else begin
        r_code <= TTX_SPACE;
        r_gfx  <= 1'b0;
        r_sep  <= 1'b0;
        r_hide <= 1'b0;
      end
    end
  end

  assign ttx.CODE     = r_code;
  assign ttx.GFX      = r_gfx;
  assign ttx.SEP      = r_sep;
  assign ttx.FG       = r_fg;
  assign ttx.BG       = r_bg;
  assign ttx.HIDE     = r_hide;
  assign ttx.DH       = r_dh;
  assign ttx.DH_LOWER = r_dh_lower;
  assign ttx.LINE     = r_line;

endmodule
